// File: rtl/ika2151_timer.sv
// ika2151_timer: OPM Timer A (10-bit) and Timer B (8-bit with /16 prescaler).
// Counters step once per sample (CYCLE_31 on a phi1 negative-edge enable).
// They produce the status flags, IRQ_n and the Timer A overflow pulse used for CSM key-on.
// Optional build macro IKA2151_TIMER_STATUS_READ_EN adds two ports:
// a counter read-back port and a freeze input.
module ika2151_timer (
    input  logic        i_EMUCLK,
    input  logic        i_MRST_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_CYCLE_31,
    input  logic [9:0]  i_TA_VAL,
    input  logic [7:0]  i_TB_VAL,
    input  logic        i_TA_LD,
    input  logic        i_TB_LD,
    input  logic        i_TA_IRQEN,
    input  logic        i_TB_IRQEN,
    input  logic        i_TA_FRST,
    input  logic        i_TB_FRST,
`ifdef IKA2151_TIMER_STATUS_READ_EN
    input  logic        i_TIMER_FREEZE,
    output logic [17:0] o_TIMER_CNT_RD,
`endif
    output logic        o_TA_FLAG,
    output logic        o_TB_FLAG,
    output logic        o_IRQ_n,
    output logic        o_TA_OVFL
);

    logic       en;
    logic       tick;
    logic       ta_rise, tb_rise;
    logic       tb_step;
    logic       ta_ovfl, tb_ovfl;

    logic [9:0] cnt_a_q, cnt_a_d;
    logic [7:0] cnt_b_q, cnt_b_d;
    logic [3:0] presc_q, presc_d;
    logic       ta_ld_q, ta_ld_d;
    logic       tb_ld_q, tb_ld_d;
    logic       ta_flag_q, ta_flag_d;
    logic       tb_flag_q, tb_flag_d;
    logic       ta_ovfl_q, ta_ovfl_d;

    assign en = ~i_phi1_NCEN_n;

`ifdef IKA2151_TIMER_STATUS_READ_EN
    logic [17:0] cnt_rd_q, cnt_rd_d;
    // Freeze only suppresses sample ticks; loads and flag clears keep working.
    assign tick = en & i_CYCLE_31 & ~i_TIMER_FREEZE;
    assign o_TIMER_CNT_RD = cnt_rd_q;
`else
    assign tick = en & i_CYCLE_31;
`endif

    // A load rise always wins over a tick on the same edge, so it can never overflow.
    assign ta_rise = i_TA_LD & ~ta_ld_q;
    assign tb_rise = i_TB_LD & ~tb_ld_q;
    assign tb_step = tick & (presc_q == 4'd15);
    assign ta_ovfl = i_TA_LD & ~ta_rise & tick    & (cnt_a_q == 10'd1023);
    assign tb_ovfl = i_TB_LD & ~tb_rise & tb_step & (cnt_b_q == 8'd255);

    // Next-state for counters, prescaler, load edge detectors, flags and overflow pulse.
    always_comb begin
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        presc_d   = presc_q;
        ta_ld_d   = ta_ld_q;
        tb_ld_d   = tb_ld_q;
        ta_flag_d = ta_flag_q;
        tb_flag_d = tb_flag_q;
        ta_ovfl_d = ta_ovfl_q;
        if (en) begin
            ta_ld_d   = i_TA_LD;
            tb_ld_d   = i_TB_LD;
            ta_ovfl_d = ta_ovfl;

            if (ta_rise) begin
                cnt_a_d = i_TA_VAL;
            end else if (i_TA_LD && tick) begin
                cnt_a_d = ta_ovfl ? i_TA_VAL : cnt_a_q + 10'd1;
            end

            // Prescaler free-runs on ticks and is never realigned by a load.
            if (tick) begin
                presc_d = presc_q + 4'd1;
            end

            if (tb_rise) begin
                cnt_b_d = i_TB_VAL;
            end else if (i_TB_LD && tb_step) begin
                cnt_b_d = tb_ovfl ? i_TB_VAL : cnt_b_q + 8'd1;
            end

            // Setting by an overflow takes precedence over a coincident clear.
            if (ta_ovfl && i_TA_IRQEN) begin
                ta_flag_d = 1'b1;
            end else if (i_TA_FRST) begin
                ta_flag_d = 1'b0;
            end

            if (tb_ovfl && i_TB_IRQEN) begin
                tb_flag_d = 1'b1;
            end else if (i_TB_FRST) begin
                tb_flag_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low core reset.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            presc_q   <= '0;
            ta_ld_q   <= 1'b0;
            tb_ld_q   <= 1'b0;
            ta_flag_q <= 1'b0;
            tb_flag_q <= 1'b0;
            ta_ovfl_q <= 1'b0;
        end else begin
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            presc_q   <= presc_d;
            ta_ld_q   <= ta_ld_d;
            tb_ld_q   <= tb_ld_d;
            ta_flag_q <= ta_flag_d;
            tb_flag_q <= tb_flag_d;
            ta_ovfl_q <= ta_ovfl_d;
        end
    end

`ifdef IKA2151_TIMER_STATUS_READ_EN
    // Read-back snapshot of both counters, refreshed on every enabled edge.
    always_comb begin
        cnt_rd_d = cnt_rd_q;
        if (en) begin
            cnt_rd_d = {cnt_b_q, cnt_a_q};
        end
    end

    // Read-back register.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            cnt_rd_q <= '0;
        end else begin
            cnt_rd_q <= cnt_rd_d;
        end
    end
`endif

    assign o_TA_FLAG = ta_flag_q;
    assign o_TB_FLAG = tb_flag_q;
    assign o_TA_OVFL = ta_ovfl_q;
    assign o_IRQ_n   = ~(ta_flag_q | tb_flag_q);

endmodule
